mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store unit between the CPU memory stage and the word-wide data RAM. It accepts byte, halfword and word load/store requests at byte addresses and drives the RAM's word-indexed read/write port. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. Misaligned and out-of-range accesses return an error and never touch the RAM.

Parameters:
RAM_DEPTH, 256, number of 32-bit words in the RAM; a word index >= RAM_DEPTH is out of range.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  unit can accept a request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and raises an error
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  qualified by resp_valid: misaligned, out-of-range or illegal size
ram_read  output  1  RAM read enable
ram_write  output  1  RAM write enable
ram_addr  output  32  RAM word index = latched req_addr[31:2]
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data

Behaviour:
- RAM contract: ram_rdata is valid combinationally in the same cycle ram_read=1 and ram_addr are presented. A write commits at the rising edge while ram_write=1.
- Little-endian byte lanes. Lane k = bits [8k+7:8k], selected by addr[1:0]. A halfword uses lanes {1,0} when addr[1]=0 and lanes {3,2} when addr[1]=1.
- FSM states are IDLE, LOAD, RMW_RD, WRITE and RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid and req_ready are both high; all req_* fields are latched at that edge.
  - Error check, in priority order: illegal size; then misaligned (half with addr[0]=1, word with addr[1:0]!=0); then addr[31:2] >= RAM_DEPTH. Any error goes to RESP with err=1.
  - Otherwise: a load goes to LOAD, a word store goes to WRITE, a byte or half store goes to RMW_RD.
- LOAD: ram_read=1. The extracted and extended ram_rdata is captured into resp_rdata at the edge. Next state is RESP.
- RMW_RD: ram_read=1. The full word is captured into an internal merge register. Next state is WRITE.
- WRITE:
  - ram_write=1.
  - ram_wdata is req_wdata for a word store.
  - For a sub-word store, ram_wdata is the merge register with only the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
  - Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata and resp_err stable. Next state is IDLE. No request is accepted in RESP.
- Latency from the accept edge to the resp_valid cycle: error 1 cycle, load 2, word store 2, sub-word store 3. Back-to-back throughput is one request per (latency+1) cycles.
- ram_addr holds the latched word index in LOAD, RMW_RD and WRITE, and is 0 otherwise.
- ram_read and ram_write are 0 outside their states and are never high together.
- Reset (rst_n=0 at an edge):
  - state returns to IDLE; resp_valid, resp_err and resp_rdata become 0; the merge register clears.
  - ram_read and ram_write are gated with rst_n, so a reset asserted during a WRITE cycle suppresses that write.
  - An in-flight request is dropped with no response.
- Inputs arriving while req_ready=0 are ignored. The CPU holds req_valid until it is accepted.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF → RAM word 4 = 0xDEADBEEF, resp_valid 2 cycles after accept. Load word from 0x10 → resp_rdata 0xDEADBEEF, err=0, 2-cycle latency.
- Byte RMW: word 4 = 0x11223344; store byte 0xAA at 0x12 → word 4 = 0x11AA3344, exactly one ram_write pulse, 3-cycle latency.
- Extension: word 4 = 0x11AA3344. Signed byte load at 0x12 → 0xFFFFFFAA. Unsigned → 0x000000AA. Signed half load at 0x12 → 0x000011AA.
- Errors: half load at 0x13, word store at 0x22, and word load at 0x400 (index 256) each give err=1 and resp_rdata 0 in 1 cycle, with ram_read and ram_write never asserted and RAM contents unchanged.
- Reset mid-RMW: drive rst_n low during the WRITE cycle of a byte store → no RAM write occurs, req_ready=1 on the next cycle, no resp_valid is seen.
- Back-to-back: hold req_valid with two loads → second is accepted only after the RESP cycle of the first, and both responses are correct.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and a word-wide data RAM.
// Byte/half stores use read-modify-write; loads are sign- or zero-extended.
module mem_access_unit #(
  parameter int RAM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [1:0]  SZ_B    = 2'b00;
  localparam logic [1:0]  SZ_H    = 2'b01;
  localparam logic [1:0]  SZ_W    = 2'b10;
  localparam logic [31:0] DEPTH_W = 32'(RAM_DEPTH);

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [2:0]  state;
  req_t        r;
  logic [31:0] merge;
  logic        acc_err;
  logic        ram_busy;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] wr_word;

  // Priority: illegal size, then misalignment, then range.
  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11)                          acc_err = 1'b1;
    else if (req_size == SZ_H && req_addr[0])       acc_err = 1'b1;
    else if (req_size == SZ_W && req_addr[1:0] != 2'b00) acc_err = 1'b1;
    else if ({2'b00, req_addr[31:2]} >= DEPTH_W)    acc_err = 1'b1;
  end

  always_comb begin
    case (r.addr[1:0])
      2'd0:    ld_byte = ram_rdata[7:0];
      2'd1:    ld_byte = ram_rdata[15:8];
      2'd2:    ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    ld_half = r.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (r.size)
      SZ_B:    ld_ext = {{24{~r.uns & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = {{16{~r.uns & ld_half[15]}}, ld_half};
      default: ld_ext = ram_rdata;
    endcase
  end

  // Sub-word merge: each lane takes new data only when addressed.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic hit;
    assign hit = (r.size == SZ_B && r.addr[1:0] == 2'(k)) ||
                 (r.size == SZ_H && r.addr[1] == 1'(k / 2));
    assign wr_word[8*k +: 8] = !hit ? merge[8*k +: 8] :
                               (r.size == SZ_H && (k % 2) == 1) ? r.wdata[15:8] : r.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '0;
      merge      <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r.we       <= req_we;
          r.size     <= req_size;
          r.uns      <= req_unsigned;
          r.addr     <= req_addr;
          r.wdata    <= req_wdata;
          resp_err   <= acc_err;
          resp_rdata <= '0;
          if (acc_err)             state <= RESP;
          else if (!req_we)        state <= LOAD;
          else if (req_size == SZ_W) state <= WRITE;
          else                     state <= RMW_RD;
        end
        LOAD: begin
          resp_rdata <= ld_ext;
          state      <= RESP;
        end
        RMW_RD: begin
          merge <= ram_rdata;
          state <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_busy   = (state == LOAD) || (state == RMW_RD) || (state == WRITE);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // Gating with rst_n lets a reset in the WRITE cycle cancel the commit.
  assign ram_read   = rst_n && ((state == LOAD) || (state == RMW_RD));
  assign ram_write  = rst_n && (state == WRITE);
  assign ram_addr   = ram_busy ? {2'b00, r.addr[31:2]} : 32'd0;
  assign ram_wdata  = (state != WRITE) ? 32'd0 : (r.size == SZ_W) ? r.wdata : wr_word;

endmodule
